// File: rtl/saradc_pkg.sv
// saradc_pkg: shared state encoding and sizing helpers for the SAR controller.
package saradc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMP,
    CONV,
    DONE,
    OUT
  } saradc_sar_state_t;

  // Accumulator / DOUT width: room for 2^max_osr full-scale codes.
  function automatic int saradc_acc_width(input int nbits, input int max_osr);
    return nbits + max_osr;
  endfunction

  // Oversample requests beyond what the accumulator was sized for saturate.
  function automatic int saradc_clamp_osr(input int osr, input int max_osr);
    return (osr > max_osr) ? max_osr : osr;
  endfunction

endpackage

// File: rtl/saradc_sar_reg.sv
// saradc_sar_reg: one-hot bit pointer walking MSB to LSB, recording each
// comparator decision into the RESULTP/RESULTN switch vectors.
module saradc_sar_reg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic             cmpo_i,
  output logic [NBITS-1:0] resp_o,
  output logic [NBITS-1:0] resn_o,
  output logic             last_o
);

  logic [NBITS-1:0] ptr_q;
  logic [NBITS-1:0] resp_q;
  logic [NBITS-1:0] resn_q;

  // Clear re-arms the pointer at the MSB; each step commits one decision.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      ptr_q  <= {1'b1, {(NBITS-1){1'b0}}};
      resp_q <= '0;
      resn_q <= '0;
    end else if (step_i) begin
      ptr_q  <= ptr_q >> 1;
      resp_q <= resp_q | (ptr_q & {NBITS{cmpo_i}});
      resn_q <= resn_q | (ptr_q & {NBITS{~cmpo_i}});
    end
  end

  assign resp_o = resp_q;
  assign resn_o = resn_q;
  // Pointer sitting on bit 0 means the current step decides the LSB.
  assign last_o = ptr_q[0];

endmodule

// File: rtl/saradc_sar_ctrl_os.sv
// saradc_sar_ctrl_os: SAR conversion sequencer with run-time oversample and
// accumulate, single-shot or continuous bursts, and a ready/valid result port
// that flags dropped words with a one-cycle OVERRUN pulse.
module saradc_sar_ctrl_os
  import saradc_pkg::*;
#(
  parameter int NBITS         = 8,
  parameter int MAX_OSR       = 4,
  parameter int SAMPLE_CYCLES = 2,
  localparam int OW = (MAX_OSR > 0) ? $clog2(MAX_OSR + 1) : 1,
  localparam int AW = saradc_acc_width(NBITS, MAX_OSR)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONT,
  input  logic [OW-1:0]    OSR_LOG2,
  input  logic             CMPO,
  output logic             SAMPLE,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             VALID,
  output logic             BUSY,
  output logic [AW-1:0]    DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             OVERRUN
);

  localparam int CW  = MAX_OSR + 1;
  localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  saradc_sar_state_t state_q;
  logic [OW-1:0]     osr_q;
  logic [CW-1:0]     cnt_q;
  logic [SCW-1:0]    scnt_q;
  logic [AW-1:0]     acc_q;
  logic [AW-1:0]     dout_q;
  logic              sample_q;
  logic              valid_q;
  logic              busy_q;
  logic              dv_q;
  logic              ovr_q;

  logic [NBITS-1:0]  resp;
  logic [NBITS-1:0]  resn;
  logic              last_bit;

  logic [OW-1:0]     osr_in;
  logic [OW-1:0]     shamt;
  logic [CW-1:0]     cnt_d;
  logic [AW-1:0]     acc_d;
  logic [AW-1:0]     word_d;
  logic              more_d;
  logic              start_go;
  logic              restart;
  logic              enter_samp;
  logic              step;
  logic              xfer;

  assign osr_in     = OW'(saradc_clamp_osr(int'(OSR_LOG2), MAX_OSR));
  assign shamt      = OW'(MAX_OSR) - osr_q;
  assign cnt_d      = cnt_q + CW'(1);
  assign more_d     = cnt_d < (CW'(1) << osr_q);
  assign acc_d      = acc_q + AW'(resp);
  // Left-scale so every OSR setting lands on the same full-scale DOUT range.
  assign word_d     = acc_d << shamt;
  assign xfer       = dv_q & DOUT_READY;

  assign start_go   = (state_q == IDLE) && (START || CONT);
  assign restart    = start_go || ((state_q == OUT) && CONT);
  assign enter_samp = restart || ((state_q == DONE) && more_d);
  assign step       = (state_q == CONV);

  saradc_sar_reg #(
    .NBITS (NBITS)
  ) u_reg (
    .clk     (CLK),
    .rst     (RST),
    .clear_i (enter_samp),
    .step_i  (step),
    .cmpo_i  (CMPO),
    .resp_o  (resp),
    .resn_o  (resn),
    .last_o  (last_bit)
  );

  // Conversion sequencer, accumulator and output handshake register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      osr_q    <= '0;
      cnt_q    <= '0;
      scnt_q   <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      // A consumed word drops valid unless a new load below overrides it.
      if (xfer) begin
        dv_q <= 1'b0;
      end
      // A new burst re-latches OSR and starts a fresh accumulation.
      if (restart) begin
        osr_q <= osr_in;
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (enter_samp) begin
        state_q  <= SAMP;
        sample_q <= 1'b1;
        busy_q   <= 1'b1;
        scnt_q   <= '0;
      end
      case (state_q)
        IDLE: begin
        end
        SAMP: begin
          if (scnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
            state_q  <= CONV;
            sample_q <= 1'b0;
          end else begin
            scnt_q <= scnt_q + SCW'(1);
          end
        end
        CONV: begin
          if (last_bit) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (!more_d) begin
            // The result word is offered on the edge entering OUT so that
            // DOUT_VALID is already high during the OUT cycle.
            state_q <= OUT;
            busy_q  <= 1'b0;
            if (!dv_q || DOUT_READY) begin
              dout_q <= word_d;
              dv_q   <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
        OUT: begin
          if (!CONT) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign SAMPLE     = sample_q;
  assign RESULTP    = resp;
  assign RESULTN    = resn;
  assign VALID      = valid_q;
  assign BUSY       = busy_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dv_q;
  assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_saradc_sar_ctrl_os.sv
// Bench for saradc_sar_ctrl_os: a burst-schedule reference model predicts
// every output each cycle and also plays the comparator role on CMPO.
module tb_saradc_sar_ctrl_os;

  localparam int N  = 8;
  localparam int MO = 4;
  localparam int S  = 2;
  localparam int AW = N + MO;
  localparam int OW = 3;
  localparam int P  = S + N + 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          CONT = 1'b0;
  logic [OW-1:0] OSR_LOG2 = '0;
  logic          CMPO = 1'b0;
  logic          DOUT_READY = 1'b0;
  logic          SAMPLE, VALID, BUSY, DOUT_VALID, OVERRUN;
  logic [N-1:0]  RESULTP, RESULTN;
  logic [AW-1:0] DOUT;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  saradc_sar_ctrl_os #(.NBITS(N), .MAX_OSR(MO), .SAMPLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CONT(CONT), .OSR_LOG2(OSR_LOG2),
    .CMPO(CMPO), .SAMPLE(SAMPLE), .RESULTP(RESULTP), .RESULTN(RESULTN),
    .VALID(VALID), .BUSY(BUSY), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [N-1:0] topmask(input int j);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < j; i++) m[N-1-i] = 1'b1;
    return m;
  endfunction

  // Target supply for the comparator: explicit queue, then fixed value, then random.
  logic [N-1:0] tq[$];
  bit           fix_en = 1'b0;
  logic [N-1:0] fix_val = '0;

  // Reference model state: position inside the current burst schedule.
  bit           m_in = 1'b0;
  int           m_tau = 0, m_n = 1, m_osr = 0, m_acc = 0, m_r = 0, m_j = 0;
  bit           m_new = 1'b0, m_xfer = 1'b0;
  logic [N-1:0] m_tgt = '0;
  logic         m_cmpo = 1'b0;
  logic         e_sample = 0, e_valid = 0, e_busy = 0, e_dv = 0, e_ov = 0;
  logic [N-1:0] e_rp = '0, e_rn = '0;
  logic [AW-1:0] e_dout = '0;

  // Burst timeline: cycle tau of a burst of m_n conversions, each P cycles
  // long (S sample, N decide, 1 done), followed by a single OUT cycle.
  always @(posedge CLK) begin
    if (RST) begin
      m_in = 0; m_tau = 0; m_cmpo = 0;
      e_sample = 0; e_valid = 0; e_busy = 0; e_dv = 0; e_ov = 0;
      e_rp = '0; e_rn = '0; e_dout = '0;
    end else begin
      m_xfer = e_dv && DOUT_READY;
      e_ov = 0; e_valid = 0; m_cmpo = 0; m_new = 0;
      if (!m_in) begin
        if (START || CONT) m_new = 1;
      end else if (m_tau == m_n * P + 1) begin
        if (CONT) m_new = 1; else m_in = 0;
      end else begin
        m_tau++;
      end
      if (m_new) begin
        m_in = 1; m_tau = 1; m_acc = 0;
        m_osr = (int'(OSR_LOG2) > MO) ? MO : int'(OSR_LOG2);
        m_n = 1 << m_osr;
      end
      if (!m_in) begin
        e_sample = 0; e_busy = 0;
        if (m_xfer) e_dv = 0;
      end else if (m_tau == m_n * P + 1) begin
        e_sample = 0; e_busy = 0;
        if (!e_dv || m_xfer) begin
          e_dout = AW'(m_acc << (MO - m_osr));
          e_dv = 1;
        end else begin
          e_ov = 1;
        end
      end else begin
        m_r = (m_tau - 1) % P;
        if (m_r == 0) begin
          if (tq.size() > 0) m_tgt = tq.pop_front();
          else if (fix_en) m_tgt = fix_val;
          else m_tgt = N'($urandom);
        end
        e_busy = 1;
        e_sample = (m_r < S);
        m_j = (m_r < S) ? 0 : m_r - S;
        e_rp = m_tgt & topmask(m_j);
        e_rn = ~m_tgt & topmask(m_j);
        if (m_r == S + N) begin
          e_valid = 1;
          m_acc += int'(m_tgt);
        end else if (m_r >= S) begin
          m_cmpo = m_tgt[N-1-m_j];
        end
        if (m_xfer) e_dv = 0;
      end
    end
  end

  // Per-cycle comparison against the model, then drive the comparator.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("SAMPLE", 32'(SAMPLE), 32'(e_sample));
      chk("RESULTP", 32'(RESULTP), 32'(e_rp));
      chk("RESULTN", 32'(RESULTN), 32'(e_rn));
      chk("VALID", 32'(VALID), 32'(e_valid));
      chk("BUSY", 32'(BUSY), 32'(e_busy));
      chk("DOUT", 32'(DOUT), 32'(e_dout));
      chk("DOUT_VALID", 32'(DOUT_VALID), 32'(e_dv));
      chk("OVERRUN", 32'(OVERRUN), 32'(e_ov));
    end
    CMPO = m_cmpo;
  end

  task automatic wait_for(input int which, input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      case (which)
        0: seen = VALID;
        1: seen = DOUT_VALID;
        2: seen = OVERRUN;
        default: seen = 0;
      endcase
      if (seen) break;
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int s0, nv, ns, novr;

    // Reset
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_ctrl", {27'd0, SAMPLE, VALID, BUSY, DOUT_VALID, OVERRUN}, 32'd0);
    chk("rst_data", {RESULTP, RESULTN, DOUT}, 32'd0);
    RST = 1'b0;

    // Single shot, OSR=0, target 0xA5
    @(negedge CLK);
    tq.push_back(8'hA5);
    OSR_LOG2 = 3'd0;
    START = 1'b1;
    s0 = cyc;
    @(negedge CLK);
    START = 1'b0;
    wait_for(0, 40, seen);
    chk("t1_valid_seen", 32'(seen), 32'd1);
    chk("t1_valid_cycle", 32'(cyc - s0), 32'd11);
    chk("t1_resultp", 32'(RESULTP), 32'hA5);
    chk("t1_resultn", 32'(RESULTN), 32'h5A);
    @(negedge CLK);
    chk("t1_dv_cycle", 32'(cyc - s0), 32'd12);
    chk("t1_dv", 32'(DOUT_VALID), 32'd1);
    chk("t1_dout", 32'(DOUT), 32'hA50);
    @(negedge CLK);
    chk("t1_busy_after", 32'(BUSY), 32'd0);
    DOUT_READY = 1'b1;
    @(negedge CLK);
    DOUT_READY = 1'b0;

    // OSR=2, four targets
    tq.push_back(8'h10); tq.push_back(8'h11);
    tq.push_back(8'h12); tq.push_back(8'h13);
    OSR_LOG2 = 3'd2;
    START = 1'b1;
    nv = 0; ns = 0; seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (VALID) nv++;
      if (SAMPLE) ns++;
      if (DOUT_VALID) begin seen = 1; break; end
    end
    chk("t2_dv_seen", 32'(seen), 32'd1);
    chk("t2_valid_count", 32'(nv), 32'd4);
    chk("t2_sample_cycles", 32'(ns), 32'd8);
    chk("t2_dout", 32'(DOUT), 32'h118);
    @(negedge CLK);
    DOUT_READY = 1'b1;
    @(negedge CLK);
    DOUT_READY = 1'b0;

    // Continuous with READY low: hold, overrun, coincident load
    fix_en = 1'b1; fix_val = 8'h7F;
    OSR_LOG2 = 3'd0;
    CONT = 1'b1;
    wait_for(1, 40, seen);
    chk("t3_first_seen", 32'(seen), 32'd1);
    chk("t3_first_word", 32'(DOUT), 32'h7F0);
    wait_for(2, 40, seen);
    chk("t3_overrun_seen", 32'(seen), 32'd1);
    chk("t3_held_word", 32'(DOUT), 32'h7F0);
    fix_val = 8'h3C;
    @(negedge CLK);
    chk("t3_overrun_width", 32'(OVERRUN), 32'd0);
    wait_for(0, 40, seen);
    chk("t3_done_seen", 32'(seen), 32'd1);
    DOUT_READY = 1'b1;
    @(negedge CLK);
    DOUT_READY = 1'b0;
    chk("t3_coincide_dv", 32'(DOUT_VALID), 32'd1);
    chk("t3_coincide_ovr", 32'(OVERRUN), 32'd0);
    chk("t3_coincide_word", 32'(DOUT), 32'h3C0);
    DOUT_READY = 1'b1;
    novr = 0;
    for (int i = 0; i < 3 * P + 3; i++) begin
      @(negedge CLK);
      if (OVERRUN) novr++;
    end
    chk("t3_no_overrun", 32'(novr), 32'd0);
    CONT = 1'b0;
    repeat (2 * P + 2) @(negedge CLK);
    chk("t3_idle_busy", 32'(BUSY), 32'd0);
    DOUT_READY = 1'b0;

    // OSR_LOG2=7 clamps to 4, full-scale codes
    fix_val = 8'hFF;
    OSR_LOG2 = 3'd7;
    START = 1'b1;
    nv = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      START = 1'b0;
      if (VALID) nv++;
      if (DOUT_VALID) begin seen = 1; break; end
    end
    chk("t4_dv_seen", 32'(seen), 32'd1);
    chk("t4_valid_count", 32'(nv), 32'd16);
    chk("t4_dout", 32'(DOUT), 32'hFF0);
    fix_en = 1'b0;

    // Reset during conversion at k=3 with a word still pending
    OSR_LOG2 = 3'd0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("t5_in_conv", 32'({SAMPLE, BUSY}), 32'b01);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("t5_rst_ctrl", {27'd0, SAMPLE, VALID, BUSY, DOUT_VALID, OVERRUN}, 32'd0);
    chk("t5_rst_data", {RESULTP, RESULTN, DOUT}, 32'd0);
    tq.push_back(8'h3B);
    pulse_start();
    wait_for(0, 40, seen);
    chk("t5_fresh_seen", 32'(seen), 32'd1);
    chk("t5_fresh_result", 32'(RESULTP), 32'h3B);
    @(negedge CLK);
    chk("t5_fresh_dout", 32'(DOUT), 32'h3B0);

    // Randomized operation against the model
    for (int i = 0; i < 2500; i++) begin
      @(negedge CLK);
      START = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 60) == 0) CONT = ~CONT;
      DOUT_READY = ($urandom_range(0, 2) != 0);
      OSR_LOG2 = ($urandom_range(0, 5) == 0) ? OW'($urandom_range(0, 7)) : OW'($urandom_range(0, 1));
      RST = ($urandom_range(0, 400) == 0);
    end
    @(negedge CLK);
    RST = 1'b0;
    START = 1'b0;
    CONT = 1'b0;
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
